// File: rtl/nf_trace_buf.sv
// Retired-instruction trace buffer: circular capture of {retire index, pc, instr}
// with continuous, one-shot and pc-trigger modes, indexed readout and a cycle-limit halt request.
module nf_trace_buf #(
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned PC_W    = 32,
  parameter int unsigned INSTR_W = 32,
  parameter int unsigned CNT_W   = 32,
  localparam int unsigned AW     = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ret_vld,
  input  logic [PC_W-1:0]    ret_pc,
  input  logic [INSTR_W-1:0] ret_instr,
  input  logic [1:0]         mode,
  input  logic               arm,
  input  logic [PC_W-1:0]    trig_pc,
  input  logic [AW-1:0]      post_cnt,
  input  logic [CNT_W-1:0]   cyc_limit,
  input  logic [AW-1:0]      rd_addr,
  output logic [PC_W-1:0]    rd_pc,
  output logic [INSTR_W-1:0] rd_instr,
  output logic [CNT_W-1:0]   rd_cyc,
  output logic               rd_vld,
  output logic [AW:0]        count,
  output logic [1:0]         state,
  output logic               halt_req
);

  localparam int unsigned E_W  = CNT_W + PC_W + INSTR_W;
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, POST = 2'd2, DONE = 2'd3} state_e;
  typedef enum logic [1:0] {M_OFF = 2'd0, M_CONT = 2'd1, M_ONESHOT = 2'd2, M_TRIG = 2'd3} mode_e;

  state_e             state_q, state_d;
  mode_e              mode_q, mode_d;
  logic [PC_W-1:0]    trig_q, trig_d;
  logic [AW-1:0]      post_q, post_d;
  logic [CNT_W-1:0]   lim_q, lim_d;
  logic [AW-1:0]      wptr_q, wptr_d;
  logic [AW:0]        count_q, count_d;
  logic [CNT_W-1:0]   rcnt_q, rcnt_d;
  logic [AW-1:0]      rem_q, rem_d;
  logic               halt_q, halt_d;
  logic               rd_vld_q, rd_vld_d;
  logic [PC_W-1:0]    rd_pc_q, rd_pc_d;
  logic [INSTR_W-1:0] rd_instr_q, rd_instr_d;
  logic [CNT_W-1:0]   rd_cyc_q, rd_cyc_d;

  logic [E_W-1:0]     mem_q [DEPTH];
  logic               wr_en;
  logic [E_W-1:0]     wr_data;
  logic [AW-1:0]      oldest;
  logic [AW-1:0]      rd_idx;
  logic [E_W-1:0]     rd_entry;

  assign wr_data = {rcnt_q, ret_pc, ret_instr};

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    trig_d  = trig_q;
    post_d  = post_q;
    lim_d   = lim_q;
    wptr_d  = wptr_q;
    count_d = count_q;
    rcnt_d  = rcnt_q;
    rem_d   = rem_q;
    halt_d  = halt_q;
    wr_en   = 1'b0;
    // arm has priority over a same-cycle retire, which is then neither stored nor counted
    if (arm) begin
      if (mode != M_OFF) begin
        state_d = RUN;
        mode_d  = mode_e'(mode);
        trig_d  = trig_pc;
        post_d  = post_cnt;
        lim_d   = cyc_limit;
        wptr_d  = '0;
        count_d = '0;
        rcnt_d  = '0;
        rem_d   = '0;
        halt_d  = 1'b0;
      end else if (state_q != IDLE) begin
        state_d = IDLE;
        halt_d  = 1'b0;
      end
    end else if (ret_vld && (state_q == RUN || state_q == POST)) begin
      wr_en  = 1'b1;
      wptr_d = wptr_q + 1'b1;
      rcnt_d = rcnt_q + 1'b1;
      if (count_q != FULL) count_d = count_q + 1'b1;
      if (lim_q != '0 && rcnt_d == lim_q) halt_d = 1'b1;
      if (state_q == RUN) begin
        if (mode_q == M_ONESHOT && count_d == FULL) state_d = DONE;
        if (mode_q == M_TRIG && ret_pc == trig_q) begin
          rem_d   = post_q;
          state_d = (post_q == '0) ? DONE : POST;
        end
      end else begin
        rem_d = rem_q - 1'b1;
        if (rem_q == AW'(1)) state_d = DONE;
      end
    end
  end

  // Oldest entry sits at the write pointer once the ring has filled
  assign oldest   = (count_q == FULL) ? wptr_q : '0;
  assign rd_idx   = oldest + rd_addr;
  assign rd_entry = mem_q[rd_idx];

  always_comb begin
    rd_vld_d   = ({1'b0, rd_addr} < count_q);
    rd_cyc_d   = '0;
    rd_pc_d    = '0;
    rd_instr_d = '0;
    if (rd_vld_d) {rd_cyc_d, rd_pc_d, rd_instr_d} = rd_entry;
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wptr_q] <= wr_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      mode_q     <= M_OFF;
      trig_q     <= '0;
      post_q     <= '0;
      lim_q      <= '0;
      wptr_q     <= '0;
      count_q    <= '0;
      rcnt_q     <= '0;
      rem_q      <= '0;
      halt_q     <= 1'b0;
      rd_vld_q   <= 1'b0;
      rd_pc_q    <= '0;
      rd_instr_q <= '0;
      rd_cyc_q   <= '0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      trig_q     <= trig_d;
      post_q     <= post_d;
      lim_q      <= lim_d;
      wptr_q     <= wptr_d;
      count_q    <= count_d;
      rcnt_q     <= rcnt_d;
      rem_q      <= rem_d;
      halt_q     <= halt_d;
      rd_vld_q   <= rd_vld_d;
      rd_pc_q    <= rd_pc_d;
      rd_instr_q <= rd_instr_d;
      rd_cyc_q   <= rd_cyc_d;
    end
  end

  assign rd_pc    = rd_pc_q;
  assign rd_instr = rd_instr_q;
  assign rd_cyc   = rd_cyc_q;
  assign rd_vld   = rd_vld_q;
  assign count    = count_q;
  assign state    = state_q;
  assign halt_req = halt_q;

endmodule

// File: tb/tb_nf_trace_buf.sv
// Self-checking bench for nf_trace_buf: a behavioural capture model fills an expected-entry
// queue as retires are driven; readout pops that queue and compares against the DUT.
module tb_nf_trace_buf;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        ret_vld;
  logic [31:0] ret_pc;
  logic [31:0] ret_instr;
  logic [1:0]  mode;
  logic        arm;
  logic [31:0] trig_pc;
  logic [3:0]  post_cnt;
  logic [31:0] cyc_limit;
  logic [3:0]  rd_addr;
  logic [31:0] rd_pc;
  logic [31:0] rd_instr;
  logic [31:0] rd_cyc;
  logic        rd_vld;
  logic [4:0]  count;
  logic [1:0]  state;
  logic        halt_req;

  nf_trace_buf #(.DEPTH(16), .PC_W(32), .INSTR_W(32), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .ret_vld(ret_vld), .ret_pc(ret_pc), .ret_instr(ret_instr),
    .mode(mode), .arm(arm), .trig_pc(trig_pc), .post_cnt(post_cnt), .cyc_limit(cyc_limit),
    .rd_addr(rd_addr), .rd_pc(rd_pc), .rd_instr(rd_instr), .rd_cyc(rd_cyc), .rd_vld(rd_vld),
    .count(count), .state(state), .halt_req(halt_req)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] cyc;
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  ent_t        exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          m_state, m_mode, m_post, m_rem;
  logic [31:0] m_trig, m_lim, m_cnt;
  bit          m_halt;

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_state = 0; m_cnt = '0; m_halt = 1'b0; m_rem = 0;
    exp_q.delete();
  endtask

  task automatic retire(logic [31:0] pc, logic [31:0] instr);
    ret_vld = 1'b1; ret_pc = pc; ret_instr = instr;
    tick();
    ret_vld = 1'b0;
    if (m_state == 1 || m_state == 2) begin
      exp_q.push_back({m_cnt, pc, instr});
      if (exp_q.size() > DEPTH) void'(exp_q.pop_front());
      m_cnt++;
      if (m_lim != 0 && m_cnt == m_lim) m_halt = 1'b1;
      if (m_state == 1) begin
        if (m_mode == 2 && exp_q.size() == DEPTH) m_state = 3;
        else if (m_mode == 3 && pc == m_trig) begin
          m_rem   = m_post;
          m_state = (m_post == 0) ? 3 : 2;
        end
      end else begin
        m_rem--;
        if (m_rem == 0) m_state = 3;
      end
    end
    check("ret_state", 64'(state), 64'(m_state));
    check("ret_count", 64'(count), 64'(exp_q.size()));
    check("ret_halt", 64'(halt_req), 64'(m_halt));
  endtask

  task automatic do_arm(logic [1:0] md, logic [31:0] tpc, logic [3:0] pn, logic [31:0] lim,
                        bit with_ret);
    arm = 1'b1; mode = md; trig_pc = tpc; post_cnt = pn; cyc_limit = lim;
    if (with_ret) begin
      ret_vld = 1'b1; ret_pc = 32'hDEAD_0000; ret_instr = 32'hBAD0_BAD0;
    end
    tick();
    arm = 1'b0; ret_vld = 1'b0;
    if (md != 0) begin
      model_reset();
      m_state = 1; m_mode = int'(md); m_trig = tpc; m_post = int'(pn); m_lim = lim;
    end else if (m_state != 0) begin
      m_state = 0; m_halt = 1'b0;
    end
    check("arm_state", 64'(state), 64'(m_state));
    check("arm_count", 64'(count), 64'(exp_q.size()));
    check("arm_halt", 64'(halt_req), 64'(m_halt));
  endtask

  task automatic readout();
    ent_t sb[$];
    ent_t e;
    sb = exp_q;
    for (int i = 0; i < DEPTH; i++) begin
      rd_addr = 4'(i);
      tick();
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("rd_vld", 64'(rd_vld), 64'd1);
        check("rd_pc", 64'(rd_pc), 64'(e.pc));
        check("rd_instr", 64'(rd_instr), 64'(e.instr));
        check("rd_cyc", 64'(rd_cyc), 64'(e.cyc));
      end else begin
        check("rd_vld_empty", 64'(rd_vld), 64'd0);
        check("rd_pc_empty", 64'(rd_pc), 64'd0);
        check("rd_cyc_empty", 64'(rd_cyc), 64'd0);
      end
    end
  endtask

  task automatic peek(int a);
    rd_addr = 4'(a);
    tick();
  endtask

  initial begin
    logic [31:0] old_pc;
    reset = 1'b1; ret_vld = 1'b0; ret_pc = '0; ret_instr = '0; mode = '0; arm = 1'b0;
    trig_pc = '0; post_cnt = '0; cyc_limit = '0; rd_addr = '0;
    model_reset();
    m_mode = 0; m_post = 0; m_trig = '0; m_lim = '0;
    repeat (3) tick();
    check("rst_state", 64'(state), 64'd0);
    check("rst_count", 64'(count), 64'd0);
    check("rst_halt", 64'(halt_req), 64'd0);
    check("rst_rd_vld", 64'(rd_vld), 64'd0);
    reset = 1'b0;
    tick();

    // one-shot: stops at DEPTH entries
    do_arm(2'd2, '0, '0, '0, 1'b0);
    for (int k = 0; k < 20; k++) retire(32'h100 + 32'(4 * k), 32'hC0DE_0000 | 32'(k));
    check("os_state", 64'(state), 64'd3);
    check("os_count", 64'(count), 64'd16);
    peek(0);
    check("os_pc0", 64'(rd_pc), 64'h100);
    check("os_cyc0", 64'(rd_cyc), 64'd0);
    peek(15);
    check("os_pc15", 64'(rd_pc), 64'h13C);
    readout();

    // continuous: overwrites oldest
    do_arm(2'd1, '0, '0, '0, 1'b0);
    for (int k = 0; k < 20; k++) retire(32'h100 + 32'(4 * k), 32'hAB00_0000 | 32'(k));
    check("ct_state", 64'(state), 64'd1);
    check("ct_count", 64'(count), 64'd16);
    peek(0);
    check("ct_pc0", 64'(rd_pc), 64'h110);
    check("ct_cyc0", 64'(rd_cyc), 64'd4);
    peek(15);
    check("ct_pc15", 64'(rd_pc), 64'h14C);
    check("ct_cyc15", 64'(rd_cyc), 64'd19);
    // write into the slot being read returns the pre-write contents
    old_pc = exp_q[0].pc;
    rd_addr = 4'd0;
    retire(32'h150, 32'hAB00_0014);
    check("ct_rw_same_slot", 64'(rd_pc), 64'(old_pc));
    readout();

    // pc trigger with post-trigger window
    do_arm(2'd3, 32'h120, 4'd3, '0, 1'b0);
    for (int k = 0; k < 20; k++) retire(32'h100 + 32'(4 * k), 32'h7700_0000 | 32'(k));
    check("tr_state", 64'(state), 64'd3);
    check("tr_count", 64'(count), 64'd12);
    peek(11);
    check("tr_last_pc", 64'(rd_pc), 64'h12C);
    readout();

    // cycle limit halt request
    do_arm(2'd1, '0, '0, 32'd200, 1'b0);
    for (int k = 0; k < 250; k++) begin
      retire(32'h1000 + 32'(4 * k), 32'(k));
      if (k == 198) check("halt_before", 64'(halt_req), 64'd0);
      if (k == 199) check("halt_rise", 64'(halt_req), 64'd1);
    end
    check("halt_sticky", 64'(halt_req), 64'd1);
    do_arm(2'd1, '0, '0, '0, 1'b0);
    check("halt_cleared", 64'(halt_req), 64'd0);

    // arm beats a same-cycle retire
    do_arm(2'd1, '0, '0, '0, 1'b1);
    check("armret_count", 64'(count), 64'd0);
    retire(32'h300, 32'h3333_3333);
    check("armret_count1", 64'(count), 64'd1);
    peek(0);
    check("armret_cyc", 64'(rd_cyc), 64'd0);
    check("armret_pc", 64'(rd_pc), 64'h300);

    // asynchronous reset in the middle of a post-trigger window
    do_arm(2'd3, 32'h108, 4'd5, 32'd50, 1'b0);
    rd_addr = 4'd0;
    for (int k = 0; k < 4; k++) retire(32'h100 + 32'(4 * k), 32'h5500_0000 | 32'(k));
    check("mid_post_state", 64'(state), 64'd2);
    check("mid_post_rdvld", 64'(rd_vld), 64'd1);
    #2;
    reset = 1'b1;
    #1;
    check("arst_state", 64'(state), 64'd0);
    check("arst_count", 64'(count), 64'd0);
    check("arst_halt", 64'(halt_req), 64'd0);
    check("arst_rd_vld", 64'(rd_vld), 64'd0);
    check("arst_rd_pc", 64'(rd_pc), 64'd0);
    check("arst_rd_instr", 64'(rd_instr), 64'd0);
    check("arst_rd_cyc", 64'(rd_cyc), 64'd0);
    model_reset();
    tick();
    reset = 1'b0;
    retire(32'h200, 32'h2222_2222);
    check("post_rst_idle_count", 64'(count), 64'd0);

    // trigger with no post window, then disarm keeps contents
    do_arm(2'd3, 32'h10C, 4'd0, '0, 1'b0);
    for (int k = 0; k < 6; k++) retire(32'h100 + 32'(4 * k), 32'h4400_0000 | 32'(k));
    check("tr0_state", 64'(state), 64'd3);
    check("tr0_count", 64'(count), 64'd4);
    peek(3);
    check("tr0_last_pc", 64'(rd_pc), 64'h10C);
    peek(4);
    check("tr0_beyond_vld", 64'(rd_vld), 64'd0);
    do_arm(2'd0, '0, '0, '0, 1'b0);
    retire(32'h900, 32'h9999_9999);
    readout();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
